// File: rtl/vip_axi4_types_pkg.sv
// Shared AXI4 VIP types: burst/size encodings, address-generator error
// codes and protocol limits used by the beat address generator.
package vip_axi4_types_pkg;

    localparam int VIP_AXI4_MAX_LENGTH_C          = 256;
    localparam int VIP_AXI4_4K_ADDRESS_BOUNDARY_C = 4096;

    typedef enum logic [1:0] {
        VIP_AXI4_BURST_FIXED = 2'b00,
        VIP_AXI4_BURST_INCR  = 2'b01,
        VIP_AXI4_BURST_WRAP  = 2'b10,
        VIP_AXI4_BURST_RSVD  = 2'b11
    } vip_axi4_burst_t;

    typedef enum logic [2:0] {
        VIP_AXI4_SIZE_1B   = 3'd0,
        VIP_AXI4_SIZE_2B   = 3'd1,
        VIP_AXI4_SIZE_4B   = 3'd2,
        VIP_AXI4_SIZE_8B   = 3'd3,
        VIP_AXI4_SIZE_16B  = 3'd4,
        VIP_AXI4_SIZE_32B  = 3'd5,
        VIP_AXI4_SIZE_64B  = 3'd6,
        VIP_AXI4_SIZE_128B = 3'd7
    } vip_axi4_size_t;

    // Lower value = higher priority when several rules are broken
    typedef enum logic [1:0] {
        VIP_AXI4_ERR_RESERVED_BURST = 2'd0,
        VIP_AXI4_ERR_SIZE           = 2'd1,
        VIP_AXI4_ERR_LEN            = 2'd2,
        VIP_AXI4_ERR_4K             = 2'd3
    } vip_axi4_addr_gen_err_t;

    // WRAP bursts may only be 2, 4, 8 or 16 beats long
    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/vip_axi4_beat_strb.sv
// Byte-lane mask for one beat: lanes from the address lane up to the
// next transfer-size aligned boundary within the data bus.
module vip_axi4_beat_strb #(
    parameter int STRB_WIDTH_P = 8
) (
    input  logic [11:0]             addr,
    input  logic [2:0]              size,
    output logic [STRB_WIDTH_P-1:0] strb
);

    int unsigned lo;
    int unsigned hi;
    int unsigned bytes;

    // Lane window [lo, hi) derived from the address offset in the bus
    always_comb begin
        bytes = 32'd1 << size;
        lo    = 32'(addr) & 32'(STRB_WIDTH_P - 1);
        hi    = (lo & ~(bytes - 32'd1)) + bytes;
        strb  = '0;
        for (int unsigned i = 0; i < STRB_WIDTH_P; i++) begin
            strb[i] = (i >= lo) && (i < hi);
        end
    end

endmodule

// File: rtl/vip_axi4_beat_addr_gen.sv
// Expands one AXI4 AW/AR command into per-beat address/index/last/strobe.
// Optional macro VIP_AXI4_ADDR_GEN_STRB_EN enables real byte strobes.
module vip_axi4_beat_addr_gen
    import vip_axi4_types_pkg::*;
#(
    parameter int ID_WIDTH_P   = 4,
    parameter int ADDR_WIDTH_P = 32,
    parameter int DATA_WIDTH_P = 64,
    parameter int STRB_WIDTH_P = DATA_WIDTH_P / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ID_WIDTH_P-1:0]   cmd_id,
    input  logic [ADDR_WIDTH_P-1:0] cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [1:0]              cmd_burst,
    output logic                    cmd_error,
    output logic [1:0]              cmd_error_code,
    output logic                    beat_valid,
    input  logic                    beat_ready,
    output logic [ID_WIDTH_P-1:0]   beat_id,
    output logic [ADDR_WIDTH_P-1:0] beat_addr,
    output logic [7:0]              beat_index,
    output logic                    beat_last,
    output logic [STRB_WIDTH_P-1:0] beat_strb
);

    localparam int SIZE_MAX_C = $clog2(STRB_WIDTH_P);
    // Wide enough for 4095 + 256 beats * 128 bytes
    localparam int XFER_W_C = $clog2(VIP_AXI4_MAX_LENGTH_C) + 9;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH_P-1:0] addr_q;
    logic [ID_WIDTH_P-1:0]   id_q;
    logic [7:0]              len_q;
    logic [7:0]              index_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic [11:0]             wrap_mask_q;
    logic                    error_q;
    logic [1:0]              error_code_q;

    logic                    accept;
    logic                    load;
    logic                    advance;
    logic                    fail;
    logic [1:0]              fail_code;
    logic                    err_rsvd;
    logic                    err_size;
    logic                    err_len;
    logic                    err_4k;
    logic [11:0]             cmd_lo;
    logic [11:0]             cmd_bytes;
    logic [11:0]             cmd_aligned;
    logic [XFER_W_C-1:0]     cmd_xfer;
    logic [11:0]             bytes_q;
    logic [11:0]             incr_lo;
    logic [11:0]             next_lo;

    // AXI4 rule checks on the offered command, lowest code wins
    always_comb begin
        cmd_lo      = cmd_addr[11:0];
        cmd_bytes   = 12'd1 << cmd_size;
        cmd_aligned = cmd_lo & ~(cmd_bytes - 12'd1);
        cmd_xfer    = XFER_W_C'({1'b0, cmd_len} + 9'd1) << cmd_size;
        err_rsvd    = (cmd_burst == VIP_AXI4_BURST_RSVD);
        err_size    = int'(cmd_size) > SIZE_MAX_C;
        err_len     = ((cmd_burst == VIP_AXI4_BURST_WRAP) &&
                       (!wrap_len_legal(cmd_len) ||
                        ((cmd_lo & (cmd_bytes - 12'd1)) != 12'd0))) ||
                      ((cmd_burst == VIP_AXI4_BURST_FIXED) &&
                       (cmd_len > 8'd15));
        err_4k      = (cmd_burst == VIP_AXI4_BURST_INCR) &&
                      ((XFER_W_C'(cmd_aligned) + cmd_xfer) >
                       XFER_W_C'(VIP_AXI4_4K_ADDRESS_BOUNDARY_C));
        fail        = err_rsvd || err_size || err_len || err_4k;
        fail_code   = VIP_AXI4_ERR_4K;
        if (err_rsvd) begin
            fail_code = VIP_AXI4_ERR_RESERVED_BURST;
        end else if (err_size) begin
            fail_code = VIP_AXI4_ERR_SIZE;
        end else if (err_len) begin
            fail_code = VIP_AXI4_ERR_LEN;
        end
    end

    // Address of the following beat; only the 4 KB page offset moves
    always_comb begin
        bytes_q = 12'd1 << size_q;
        incr_lo = (addr_q[11:0] & ~(bytes_q - 12'd1)) + bytes_q;
        next_lo = incr_lo;
        if (burst_q == VIP_AXI4_BURST_FIXED) begin
            next_lo = addr_q[11:0];
        end else if (burst_q == VIP_AXI4_BURST_WRAP) begin
            next_lo = (addr_q[11:0] & ~wrap_mask_q) |
                      (incr_lo & wrap_mask_q);
        end
    end

    // Handshakes and next state; last beat can hand over to a new command
    always_comb begin
        beat_valid = (state_q == BURST);
        beat_last  = beat_valid && (index_q == len_q);
        advance    = beat_valid && beat_ready;
        cmd_ready  = !rst &&
                     ((state_q == IDLE) || (advance && beat_last));
        accept     = cmd_valid && cmd_ready;
        load       = accept && !fail;
        state_d    = state_q;
        if (advance && beat_last) begin
            state_d = IDLE;
        end
        if (load) begin
            state_d = BURST;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst context, beat counter and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            id_q         <= '0;
            len_q        <= '0;
            index_q      <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            wrap_mask_q  <= '0;
            error_q      <= 1'b0;
            error_code_q <= '0;
        end else begin
            error_q      <= accept && fail;
            error_code_q <= (accept && fail) ? fail_code : 2'd0;
            if (load) begin
                addr_q      <= cmd_addr;
                id_q        <= cmd_id;
                len_q       <= cmd_len;
                index_q     <= '0;
                size_q      <= cmd_size;
                burst_q     <= cmd_burst;
                wrap_mask_q <= 12'(cmd_xfer - XFER_W_C'(1));
            end else if (advance && !beat_last) begin
                addr_q[11:0] <= next_lo;
                index_q      <= index_q + 8'd1;
            end
        end
    end

    assign cmd_error      = error_q;
    assign cmd_error_code = error_code_q;
    assign beat_id        = id_q;
    assign beat_addr      = addr_q;
    assign beat_index     = index_q;

`ifdef VIP_AXI4_ADDR_GEN_STRB_EN
    logic [STRB_WIDTH_P-1:0] lane_mask;

    vip_axi4_beat_strb #(
        .STRB_WIDTH_P(STRB_WIDTH_P)
    ) u_strb (
        .addr(addr_q[11:0]),
        .size(size_q),
        .strb(lane_mask)
    );

    assign beat_strb = beat_valid ? lane_mask : '0;
`else
    assign beat_strb = '1;
`endif

endmodule

// File: tb/tb_vip_axi4_beat_addr_gen.sv
// Self-checking bench for vip_axi4_beat_addr_gen: directed cases plus
// randomized commands against an arithmetic burst model.
module tb_vip_axi4_beat_addr_gen;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [IDW-1:0] cmd_id;
    logic [AW-1:0]  cmd_addr;
    logic [7:0]     cmd_len;
    logic [2:0]     cmd_size;
    logic [1:0]     cmd_burst;
    logic           cmd_error;
    logic [1:0]     cmd_error_code;
    logic           beat_valid;
    logic           beat_ready;
    logic [IDW-1:0] beat_id;
    logic [AW-1:0]  beat_addr;
    logic [7:0]     beat_index;
    logic           beat_last;
    logic [SW-1:0]  beat_strb;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } cmd_t;

    always #5 clk = ~clk;

    vip_axi4_beat_addr_gen #(
        .ID_WIDTH_P  (IDW),
        .ADDR_WIDTH_P(AW),
        .DATA_WIDTH_P(DW),
        .STRB_WIDTH_P(SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_id        (cmd_id),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_size      (cmd_size),
        .cmd_burst     (cmd_burst),
        .cmd_error     (cmd_error),
        .cmd_error_code(cmd_error_code),
        .beat_valid    (beat_valid),
        .beat_ready    (beat_ready),
        .beat_id       (beat_id),
        .beat_addr     (beat_addr),
        .beat_index    (beat_index),
        .beat_last     (beat_last),
        .beat_strb     (beat_strb)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input int id, input int unsigned addr,
                                input int len, input int size,
                                input int burst);
        cmd_t c;
        c.id    = 4'(id);
        c.addr  = addr;
        c.len   = 8'(len);
        c.size  = 3'(size);
        c.burst = 2'(burst);
        return c;
    endfunction

    // Expected error code, -1 when the command is legal
    function automatic int exp_err(input cmd_t c);
        int unsigned b;
        int unsigned a;
        int unsigned beats;
        b     = 32'd1 << c.size;
        a     = c.addr % 4096;
        beats = int'(c.len) + 1;
        if (c.burst == 2'd3) return 0;
        if (b > SW) return 1;
        if (c.burst == 2'd2 &&
            (!(beats inside {2, 4, 8, 16}) || (a % b) != 0)) return 2;
        if (c.burst == 2'd0 && c.len > 15) return 2;
        if (c.burst == 2'd1 && ((a / b) * b + beats * b) > 4096) return 3;
        return -1;
    endfunction

    function automatic logic [31:0] exp_addr(input cmd_t c, input int n);
        int unsigned b;
        int unsigned a;
        int unsigned base;
        int unsigned t;
        int unsigned lower;
        b    = 32'd1 << c.size;
        a    = c.addr % 4096;
        base = c.addr - a;
        if (c.burst == 2'd0) return c.addr;
        if (c.burst == 2'd1) begin
            if (n == 0) return c.addr;
            return base + (a / b) * b + n * b;
        end
        t     = (int'(c.len) + 1) * b;
        lower = (a / t) * t;
        return base + lower + ((a - lower + n * b) % t);
    endfunction

    function automatic logic [SW-1:0] exp_strb(input logic [31:0] ba,
                                               input int unsigned size);
`ifdef VIP_AXI4_ADDR_GEN_STRB_EN
        int unsigned b;
        int unsigned lo;
        int unsigned hi;
        logic [SW-1:0] m;
        b  = 32'd1 << size;
        lo = ba % SW;
        hi = (lo / b) * b + b;
        m  = '0;
        for (int i = 0; i < SW; i++) begin
            if (i >= lo && i < hi) m[i] = 1'b1;
        end
        return m;
`else
        return (size < 8 && ba[0] === 1'bx) ? '0 : '1;
`endif
    endfunction

    task automatic check_beat(input cmd_t c, input int n, input string tag);
        logic [31:0] ea;
        ea = exp_addr(c, n);
        chk({tag, " valid"}, 64'(beat_valid), 64'd1);
        chk({tag, " addr"}, 64'(beat_addr), 64'(ea));
        chk({tag, " index"}, 64'(beat_index), 64'(n));
        chk({tag, " last"}, 64'(beat_last), 64'(n == int'(c.len)));
        chk({tag, " id"}, 64'(beat_id), 64'(c.id));
        chk({tag, " strb"}, 64'(beat_strb), 64'(exp_strb(ea, c.size)));
    endtask

    task automatic drive(input cmd_t c);
        cmd_valid = 1'b1;
        cmd_id    = c.id;
        cmd_addr  = c.addr;
        cmd_len   = c.len;
        cmd_size  = c.size;
        cmd_burst = c.burst;
    endtask

    // Consume beats first..first+count-1 with random backpressure
    task automatic drain(input cmd_t c, input int first, input int count,
                         input int smin, input int smax);
        int k;
        for (int n = first; n < first + count; n++) begin
            k = $urandom_range(smax, smin);
            beat_ready = 1'b0;
            repeat (k) begin
                check_beat(c, n, "stall");
                @(negedge clk);
            end
            check_beat(c, n, "beat");
            beat_ready = 1'b1;
            @(negedge clk);
            beat_ready = 1'b0;
        end
    endtask

    task automatic run(input cmd_t c, input int smin, input int smax);
        int e;
        e = exp_err(c);
        drive(c);
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (e >= 0) begin
            chk("err pulse", 64'(cmd_error), 64'd1);
            chk("err code", 64'(cmd_error_code), 64'(e));
            chk("err no beat", 64'(beat_valid), 64'd0);
            @(negedge clk);
            chk("err clear", 64'(cmd_error), 64'd0);
            chk("err no beat2", 64'(beat_valid), 64'd0);
        end else begin
            chk("no err", 64'(cmd_error), 64'd0);
            drain(c, 0, int'(c.len) + 1, smin, smax);
            chk("idle after", 64'(beat_valid), 64'd0);
        end
    endtask

    initial begin
        cmd_t c;
        cmd_t c2;
        int   r;
        logic [7:0] wl [4];
        wl = '{8'd1, 8'd3, 8'd7, 8'd15};
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        beat_ready = 1'b0;
        c = mk(0, 0, 0, 0, 0);
        drive(c);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst valid", 64'(beat_valid), 64'd0);
        chk("rst last", 64'(beat_last), 64'd0);
        chk("rst error", 64'(cmd_error), 64'd0);
        chk("rst ready", 64'(cmd_ready), 64'd0);
        chk("rst addr", 64'(beat_addr), 64'd0);
        chk("rst index", 64'(beat_index), 64'd0);
        chk("rst id", 64'(beat_id), 64'd0);
`ifdef VIP_AXI4_ADDR_GEN_STRB_EN
        chk("rst strb", 64'(beat_strb), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("post rst ready", 64'(cmd_ready), 64'd1);

        run(mk(3, 32'h1004, 3, 2, 1), 0, 1);
        run(mk(5, 32'h38, 3, 3, 2), 0, 1);
        run(mk(1, 32'hFF8, 1, 3, 1), 0, 0);
        run(mk(1, 32'h0, 2, 3, 2), 0, 0);
        run(mk(1, 32'h0, 0, 4, 3), 0, 0);
        run(mk(2, 32'h0, 0, 4, 1), 0, 0);
        run(mk(2, 32'h0, 16, 0, 0), 0, 0);
        run(mk(2, 32'h44, 3, 3, 2), 0, 0);
        run(mk(7, 32'h40, 2, 3, 0), 5, 5);
        run(mk(6, 32'h5FF0, 1, 3, 1), 0, 0);
        run(mk(9, 32'h3, 2, 2, 1), 0, 1);
        run(mk(4, 32'hA000, 255, 0, 1), 0, 0);

        c  = mk(1, 32'h100, 1, 3, 1);
        c2 = mk(2, 32'h200, 2, 2, 1);
        drive(c);
        chk("b2b ready1", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        drain(c, 0, 1, 0, 0);
        check_beat(c, 1, "b2b last");
        beat_ready = 1'b1;
        drive(c2);
        chk("b2b ready2", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid  = 1'b0;
        beat_ready = 1'b0;
        drain(c2, 0, 3, 0, 1);
        chk("b2b idle", 64'(beat_valid), 64'd0);

        c = mk(8, 32'h2000, 7, 3, 1);
        drive(c);
        @(negedge clk);
        cmd_valid = 1'b0;
        drain(c, 0, 2, 0, 0);
        check_beat(c, 2, "pre rst");
        rst = 1'b1;
        #1;
        chk("mid rst valid", 64'(beat_valid), 64'd0);
        chk("mid rst index", 64'(beat_index), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel ready", 64'(cmd_ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("no stale", 64'(beat_valid), 64'd0);
        end
        run(c, 0, 1);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(99);
            c.burst = (r < 5) ? 2'd3 : (r < 35) ? 2'd0 :
                      (r < 70) ? 2'd1 : 2'd2;
            c.size = ($urandom_range(9) == 0) ?
                     3'($urandom_range(7, 4)) : 3'($urandom_range(3));
            if (c.burst == 2'd0) begin
                c.len = 8'($urandom_range(17));
            end else if (c.burst == 2'd2) begin
                c.len = ($urandom_range(5) == 0) ?
                        8'($urandom_range(20)) : wl[$urandom_range(3)];
            end else begin
                c.len = ($urandom_range(4) == 0) ?
                        8'($urandom_range(255)) : 8'($urandom_range(15));
            end
            c.addr = $urandom;
            if (c.burst == 2'd2 && $urandom_range(4) != 0) begin
                c.addr = c.addr & ~((32'd1 << c.size) - 32'd1);
            end
            c.id = 4'($urandom);
            run(c, 0, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
